// File: rtl/evm_pkg.sv
// Shared types and helpers for the evm_tally voting machine.
package evm_pkg;

  localparam int MAX_CAND  = 16;
  localparam int MAX_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ARMED = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } evm_state_e;

  typedef enum logic [1:0] {
    VOTE_NONE  = 2'd0,
    VOTE_ONE   = 2'd1,
    VOTE_MULTI = 2'd2
  } vote_kind_e;

  // Classifies a ballot vector as empty, one-hot or multi-hot.
  function automatic vote_kind_e vote_kind(input logic [MAX_CAND-1:0] v);
    vote_kind_e k;
    if (v == {MAX_CAND{1'b0}}) begin
      k = VOTE_NONE;
    end else if ((v & (v - 16'd1)) == 16'd0) begin
      k = VOTE_ONE;
    end else begin
      k = VOTE_MULTI;
    end
    return k;
  endfunction

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                   input logic [MAX_CNT_W-1:0] max_v);
    logic [MAX_CNT_W-1:0] r;
    if (val >= max_v) begin
      r = val;
    end else begin
      r = val + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/evm_winner_scan.sv
// Sequential winner scan: one tally per cycle, lowest index wins ties.
// Optional tie tracking under EVM_TIE_DETECT_EN.
module evm_winner_scan
  import evm_pkg::*;
#(
  parameter int N_CAND = 4,
  parameter int CNT_W  = 8,
  parameter int SEL_W  = $clog2(N_CAND)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      run_i,
  input  logic [N_CAND*CNT_W-1:0]   tallies_i,
  output logic [SEL_W-1:0]          leader_idx_o,
`ifdef EVM_TIE_DETECT_EN
  output logic                      tie_o,
`endif
  output logic                      done_o
);

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] lead_idx_q, lead_idx_d;
  logic [CNT_W-1:0] lead_val_q, lead_val_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cur_s;
`ifdef EVM_TIE_DETECT_EN
  logic             tie_q, tie_d;
`endif

  // Read port into the flattened tally bus.
  always_comb begin
    cur_s = {CNT_W{1'b0}};
    for (int i = 0; i < N_CAND; i++) begin
      if (idx_q == SEL_W'(i)) begin
        cur_s = tallies_i[i*CNT_W +: CNT_W];
      end else begin
        cur_s = cur_s;
      end
    end
  end

  // Leader comparison; a zero tally never counts towards a tie.
  always_comb begin
    idx_d      = idx_q;
    lead_idx_d = lead_idx_q;
    lead_val_d = lead_val_q;
    done_d     = done_q;
`ifdef EVM_TIE_DETECT_EN
    tie_d      = tie_q;
`endif
    if (clear_i) begin
      idx_d      = {SEL_W{1'b0}};
      lead_idx_d = {SEL_W{1'b0}};
      lead_val_d = {CNT_W{1'b0}};
      done_d     = 1'b0;
`ifdef EVM_TIE_DETECT_EN
      tie_d      = 1'b0;
`endif
    end else if (run_i && !done_q) begin
      if (cur_s > lead_val_q) begin
        lead_val_d = cur_s;
        lead_idx_d = idx_q;
`ifdef EVM_TIE_DETECT_EN
        tie_d      = 1'b0;
`endif
      end else begin
`ifdef EVM_TIE_DETECT_EN
        if ((cur_s == lead_val_q) && (cur_s != {CNT_W{1'b0}})) begin
          tie_d = 1'b1;
        end else begin
          tie_d = tie_q;
        end
`endif
        lead_val_d = lead_val_q;
      end
      if (idx_q == SEL_W'(N_CAND - 1)) begin
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + SEL_W'(1);
      end
    end else begin
      done_d = done_q;
    end
  end

  // Scan state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= {SEL_W{1'b0}};
      lead_idx_q <= {SEL_W{1'b0}};
      lead_val_q <= {CNT_W{1'b0}};
      done_q     <= 1'b0;
`ifdef EVM_TIE_DETECT_EN
      tie_q      <= 1'b0;
`endif
    end else begin
      idx_q      <= idx_d;
      lead_idx_q <= lead_idx_d;
      lead_val_q <= lead_val_d;
      done_q     <= done_d;
`ifdef EVM_TIE_DETECT_EN
      tie_q      <= tie_d;
`endif
    end
  end

  assign leader_idx_o = lead_idx_q;
  assign done_o       = done_q;
`ifdef EVM_TIE_DETECT_EN
  assign tie_o        = tie_q;
`endif

endmodule

// File: rtl/evm_tally.sv
// Parametrised voting machine: armed ballots, saturating tallies, timed expiry,
// sequential winner scan. Define EVM_TIE_DETECT_EN to add the `tie` output.
module evm_tally
  import evm_pkg::*;
#(
  parameter int N_CAND  = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255,
  parameter int SEL_W   = $clog2(N_CAND)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              switch_on_evm,
  input  logic              switch_off_evm,
  input  logic              candidate_ready,
  input  logic [N_CAND-1:0] vote,
  input  logic              voting_session_done,
  input  logic              display_winner,
  input  logic [SEL_W-1:0]  display_sel,
  output logic [CNT_W-1:0]  results,
  output logic              invalid_sel,
  output logic [SEL_W-1:0]  winner_idx,
  output logic              winner_valid,
  output logic              vote_ack,
  output logic              invalid_vote,
  output logic              ballot_expired,
  output logic              voting_in_progress,
`ifdef EVM_TIE_DETECT_EN
  output logic              tie,
`endif
  output logic              voting_done
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [MAX_CNT_W-1:0] CNT_MAX = MAX_CNT_W'((1 << CNT_W) - 1);

  evm_state_e state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] tally_q [N_CAND];
  logic [CNT_W-1:0] tally_d [N_CAND];
  logic [N_CAND*CNT_W-1:0] tallies_flat_s;

  logic ack_s, inv_s, exp_s, accept_s, clr_tally_s;
  vote_kind_e kind_s;

  logic vote_ack_q, invalid_vote_q, ballot_expired_q;
  logic in_prog_q, vdone_q, wvalid_q;
  logic [SEL_W-1:0] widx_q;
  logic [SEL_W-1:0] scan_idx_s;
  logic scan_done_s;
`ifdef EVM_TIE_DETECT_EN
  logic scan_tie_s;
  logic tie_q;
`endif

  assign kind_s = vote_kind(MAX_CAND'(vote));

  // Next-state logic; switch-off overrides every state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    ack_s       = 1'b0;
    inv_s       = 1'b0;
    exp_s       = 1'b0;
    accept_s    = 1'b0;
    clr_tally_s = 1'b0;
    if (switch_off_evm) begin
      state_d     = ST_OFF;
      clr_tally_s = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (switch_on_evm) state_d = ST_IDLE;
          else               state_d = ST_OFF;
        end
        ST_IDLE: begin
          if (voting_session_done)  state_d = ST_SCAN;
          else if (candidate_ready) state_d = ST_ARMED;
          else                      state_d = ST_IDLE;
        end
        ST_ARMED: begin
          // A valid vote is counted even when the session closes the same cycle.
          if (kind_s == VOTE_ONE) begin
            accept_s = 1'b1;
            ack_s    = 1'b1;
            state_d  = voting_session_done ? ST_SCAN : ST_IDLE;
          end else if (kind_s == VOTE_MULTI) begin
            inv_s   = 1'b1;
            state_d = voting_session_done ? ST_SCAN : ST_ARMED;
          end else if (voting_session_done) begin
            state_d = ST_SCAN;
          end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
            exp_s   = 1'b1;
            state_d = ST_IDLE;
          end else if (TIMEOUT != 0) begin
            timer_d = timer_q + TMR_W'(1);
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_SCAN: begin
          if (scan_done_s) state_d = ST_DONE;
          else             state_d = ST_SCAN;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_OFF;
      endcase
    end
    if (state_d != ST_ARMED) begin
      timer_d = {TMR_W{1'b0}};
    end else begin
      timer_d = timer_d;
    end
  end

  // Tally update: clear on switch-off, saturating increment on an accepted vote.
  always_comb begin
    for (int i = 0; i < N_CAND; i++) begin
      tally_d[i] = tally_q[i];
    end
    if (clr_tally_s) begin
      for (int i = 0; i < N_CAND; i++) begin
        tally_d[i] = {CNT_W{1'b0}};
      end
    end else if (accept_s) begin
      for (int i = 0; i < N_CAND; i++) begin
        if (vote[i]) tally_d[i] = CNT_W'(sat_inc(MAX_CNT_W'(tally_q[i]), CNT_MAX));
        else         tally_d[i] = tally_q[i];
      end
    end else begin
      for (int i = 0; i < N_CAND; i++) begin
        tally_d[i] = tally_q[i];
      end
    end
  end

  // Flatten the tally array for the scanner.
  always_comb begin
    tallies_flat_s = {(N_CAND*CNT_W){1'b0}};
    for (int i = 0; i < N_CAND; i++) begin
      tallies_flat_s[i*CNT_W +: CNT_W] = tally_q[i];
    end
  end

  evm_winner_scan #(
    .N_CAND (N_CAND),
    .CNT_W  (CNT_W),
    .SEL_W  (SEL_W)
  ) u_scan (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (!((state_q == ST_SCAN) || (state_q == ST_DONE))),
    .run_i        (state_q == ST_SCAN),
    .tallies_i    (tallies_flat_s),
    .leader_idx_o (scan_idx_s),
`ifdef EVM_TIE_DETECT_EN
    .tie_o        (scan_tie_s),
`endif
    .done_o       (scan_done_s)
  );

  // State, tallies and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_OFF;
      timer_q          <= {TMR_W{1'b0}};
      for (int i = 0; i < N_CAND; i++) tally_q[i] <= {CNT_W{1'b0}};
      vote_ack_q       <= 1'b0;
      invalid_vote_q   <= 1'b0;
      ballot_expired_q <= 1'b0;
      in_prog_q        <= 1'b0;
      vdone_q          <= 1'b0;
      wvalid_q         <= 1'b0;
      widx_q           <= {SEL_W{1'b0}};
`ifdef EVM_TIE_DETECT_EN
      tie_q            <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      for (int i = 0; i < N_CAND; i++) tally_q[i] <= tally_d[i];
      vote_ack_q       <= ack_s;
      invalid_vote_q   <= inv_s;
      ballot_expired_q <= exp_s;
      in_prog_q        <= (state_d == ST_IDLE) || (state_d == ST_ARMED);
      vdone_q          <= (state_d == ST_SCAN) || (state_d == ST_DONE);
      wvalid_q         <= (state_d == ST_DONE);
      widx_q           <= ((state_d == ST_DONE) && display_winner) ? scan_idx_s : {SEL_W{1'b0}};
`ifdef EVM_TIE_DETECT_EN
      tie_q            <= (state_d == ST_DONE) && display_winner && scan_tie_s;
`endif
    end
  end

  // Display mux: tallies are only visible once the session has closed.
  always_comb begin
    invalid_sel = (int'(display_sel) >= N_CAND);
    results     = {CNT_W{1'b0}};
    if (((state_q == ST_SCAN) || (state_q == ST_DONE)) && !invalid_sel) begin
      for (int i = 0; i < N_CAND; i++) begin
        if (int'(display_sel) == i) results = tally_q[i];
        else                        results = results;
      end
    end else begin
      results = {CNT_W{1'b0}};
    end
  end

  assign vote_ack           = vote_ack_q;
  assign invalid_vote       = invalid_vote_q;
  assign ballot_expired     = ballot_expired_q;
  assign voting_in_progress = in_prog_q;
  assign voting_done        = vdone_q;
  assign winner_valid       = wvalid_q;
  assign winner_idx         = widx_q;
`ifdef EVM_TIE_DETECT_EN
  assign tie                = tie_q;
`endif

endmodule

// File: doc/evm_tally.md
# evm_tally

Parametrised successor of the team's fixed 3-candidate voting machine: supports N_CAND candidates with CNT_W-bit saturating tallies, arms one ballot per `candidate_ready`, expires unused ballots after a timeout, and scans for the winner sequentially once the session closes. It sits behind the same Tiny Tapeout top-level wrapper style, with pin mapping left to the wrapper.

## Interface
- `N_CAND`, default 4 (legal 2..16): number of candidates.
- `CNT_W`, default 8: tally width per candidate.
- `TIMEOUT`, default 255: cycles an armed ballot waits before expiring; 0 disables expiry.
- `SEL_W`, default `$clog2(N_CAND)`: width of candidate index buses (derived, do not override).

Ports:
- `clk`: input, 1 bit. Sole clock.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `switch_on_evm`: input, 1 bit. Leaves OFF.
- `switch_off_evm`: input, 1 bit. Forces OFF from any state and clears the tallies.
- `candidate_ready`: input, 1 bit. Arms one ballot.
- `vote`: input, N_CAND bits. One-hot candidate choice, level-sampled.
- `voting_session_done`: input, 1 bit. Closes the session.
- `display_winner`: input, 1 bit. Gates the winner outputs.
- `display_sel`: input, SEL_W bits. Selects the candidate whose tally drives `results`.
- `results`: output, CNT_W bits. Tally of the `display_sel` candidate.
- `invalid_sel`: output, 1 bit. High when `display_sel` ≥ N_CAND.
- `winner_idx`: output, SEL_W bits. Winning candidate index.
- `winner_valid`: output, 1 bit. High once the winner scan has finished.
- `vote_ack`: output, 1 bit. One-cycle pulse when a vote is accepted.
- `invalid_vote`: output, 1 bit. One-cycle pulse when the vote vector is multi-hot.
- `ballot_expired`: output, 1 bit. One-cycle pulse when an armed ballot times out.
- `voting_in_progress`: output, 1 bit. High in IDLE and ARMED.
- `voting_done`: output, 1 bit. High in SCAN and DONE.

## Operation
- States: OFF, IDLE, ARMED, SCAN, DONE.
- Priority order: `rst` > `switch_off_evm` > everything else.
- OFF → IDLE on `switch_on_evm`. Tallies are cleared on entry to OFF.
- IDLE → ARMED on `candidate_ready`. While ARMED, a new `candidate_ready` does not re-arm and does not restart the timer.
- ARMED with exactly one `vote` bit set:
  - the selected tally increments, saturating at 2^CNT_W−1;
  - `vote_ack` pulses;
  - state → IDLE.
- ARMED with ≥2 `vote` bits set: `invalid_vote` pulses, no tally changes, state stays ARMED.
- ARMED with `vote` = 0: the timer counts. On reaching TIMEOUT, `ballot_expired` pulses and state → IDLE.
- `voting_session_done` in IDLE or ARMED → SCAN. If a valid vote arrives in the same ARMED cycle, that vote is counted first.
- SCAN: one candidate compared per cycle, index 0 upward. A strictly greater tally replaces the leader, so ties resolve to the lowest index. Exit to DONE after N_CAND cycles.
- DONE: holds until `switch_off_evm` or `rst`. Votes and `candidate_ready` are ignored.
- `results`: equals `tally[display_sel]` in SCAN and DONE; 0 otherwise and whenever `invalid_sel` is high.
- `winner_idx`: valid only when `winner_valid && display_winner`; otherwise 0.
- All-zero tallies: `winner_idx` = 0 and `winner_valid` = 1.

## Timing
- Reset values: state OFF, all tallies 0, timer 0. Every output is 0, including all pulses.
- Outputs are registered, except `results` and `invalid_sel`, which are combinational from `display_sel` and the registered tallies.
- Vote accepted in cycle t: `vote_ack` and the updated tally are visible at t+1.
- Expiry: exactly TIMEOUT cycles in ARMED with no vote, then `ballot_expired` at the following edge.
- `winner_valid` rises N_CAND+1 cycles after the `voting_session_done` sample.
- `rst` or `switch_off_evm` mid-SCAN aborts the scan; `winner_valid` clears at the next edge.

## Configuration
- `EVM_TIE_DETECT_EN` defined:
  - adds output `tie` (1 bit);
  - the scan tracks equality with the leader;
  - `tie` = 1 in DONE when ≥2 candidates share the maximum nonzero tally, gated by `display_winner` like `winner_idx`.
- `EVM_TIE_DETECT_EN` undefined: the port and its logic are absent. Lowest-index tie resolution is unchanged either way.

## Structure
- Shared package `evm_pkg` holds:
  - the state enum (OFF/IDLE/ARMED/SCAN/DONE);
  - a one-hot/multi-hot check function;
  - the saturating-increment function.
- Sub-module `evm_winner_scan` holds the sequential max/tie scan: tally-read index counter, leader register, leader index, done flag.
- The top level owns the FSM, the timer, the tally array and the display mux.

## Test plan
- N_CAND=4, CNT_W=8: power on, arm, vote `0100` three times, then `0001` once, close → candidate 2 tally 3, candidate 0 tally 1, `winner_idx`=2, `winner_valid` at N_CAND+1 cycles after close.
- Arm, vote `0110` → `invalid_vote` pulse, no tally change, still ARMED. Then vote `0010` → `vote_ack`, candidate 1 = 1.
- TIMEOUT=5: arm, no vote → `ballot_expired` on the 6th cycle and state IDLE. A vote without a fresh arm → no count.
- CNT_W=2: 5 votes for candidate 3 → tally saturates at 3.
- Tallies 2,2,1,0 → `winner_idx`=0; with `EVM_TIE_DETECT_EN`, `tie`=1. `display_sel`=3 with N_CAND=3 → `invalid_sel`=1, `results`=0.
- `switch_off_evm` asserted during SCAN → OFF next cycle, tallies 0, `winner_valid` 0. `voting_session_done` in the same cycle as a valid vote → vote counted, then SCAN.
